// File: rtl/uart_tx.sv
// uart_tx: serial transmitter sending start, LSB-first data, optional even/odd parity and stop, one bit per clk
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_type,
    output logic                  tx_out,
    output logic                  busy
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q, par_type_q, load, last, tx_n;
    assign last = cnt == CW'(DATA_WIDTH - 1);
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        case (state)
            IDLE: begin
                load    = data_valid;
                state_n = data_valid ? START : IDLE;
            end
            START:   state_n = DATA;
            DATA: begin
                cnt_n   = last ? '0 : cnt + 1'b1;
                state_n = last ? (par_en_q ? PARITY : STOP) : DATA;
            end
            PARITY:  state_n = STOP;
            STOP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // outputs are registered, so they are derived from the state being entered
        tx_n = state_n == START  ? 1'b0 :
               state_n == DATA   ? data_q[cnt_n] :
               state_n == PARITY ? ^data_q ^ par_type_q : 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            tx_out <= tx_n;
            busy   <= state_n != IDLE;
            if (load) begin
                data_q     <= p_data;
                par_en_q   <= par_en;
                par_type_q <= par_type;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench; stimulus queues expected frames, a line monitor decodes and compares them
`timescale 1ns/1ps
module tb_uart_tx;
    logic       TX_CLK_TB = 1'b0;
    logic       rst_n, data_valid, par_en, par_type, tx_out, busy;
    logic [7:0] p_data;
    typedef struct {
        logic [10:0] bits;
        int          len;
        logic [7:0]  data;
        logic        pe, pt, full;
        int          gap;
    } exp_t;
    exp_t        exp_q[$];
    exp_t        cur;
    int          checks = 0, failures = 0, pos = -1, idle = 0;
    bit          mon_en = 0, end_chk = 0;
    logic [10:0] rb;
    logic [7:0]  rd;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .clk(TX_CLK_TB), .rst_n(rst_n), .p_data(p_data), .data_valid(data_valid),
        .par_en(par_en), .par_type(par_type), .tx_out(tx_out), .busy(busy)
    );

    always #4340 TX_CLK_TB = ~TX_CLK_TB;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic e, input logic t, input logic ep,
                                input bit ab, input int gap);
        exp_t x;
        x.bits = e ? {1'b1, ep, d, 1'b0} : {2'b11, d, 1'b0};
        x.len  = ab ? 6 : (e ? 11 : 10);
        x.data = d;
        x.pe   = e;
        x.pt   = t;
        x.full = !ab;
        x.gap  = gap;
        return x;
    endfunction

    task automatic req(input logic [7:0] d, input logic e, input logic t, input logic ep, input bit ab);
        @(negedge TX_CLK_TB);
        p_data = d; par_en = e; par_type = t; data_valid = 1'b1;
        exp_q.push_back(mk(d, e, t, ep, ab, -1));
        @(negedge TX_CLK_TB);
        data_valid = 1'b0;
    endtask

    // line monitor acting as the loopback receiver
    initial begin
        forever begin
            @(negedge TX_CLK_TB);
            if (mon_en) begin
                if (end_chk) begin
                    chk("end_busy", busy, 0);
                    chk("end_tx", tx_out, 1);
                    end_chk = 0;
                    idle = 1;
                end else if (pos == -2) begin
                    if (busy === 1'b0) pos = -1;
                end else if (pos < 0) begin
                    if (busy === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_frame: busy rose with no request queued at %0t", $time);
                            pos = -2;
                        end else begin
                            cur = exp_q.pop_front();
                            pos = 0;
                            if (cur.gap >= 0) chk("idle_gap", idle, cur.gap);
                        end
                    end else begin
                        idle++;
                        chk("idle_tx", tx_out, 1);
                    end
                end
                if (pos >= 0) begin
                    chk($sformatf("bit%0d_d%0h", pos, cur.data), tx_out, cur.bits[pos]);
                    chk("busy_in_frame", busy, 1);
                    rb[pos] = tx_out;
                    pos++;
                    if (pos == cur.len) begin
                        pos = -1;
                        end_chk = 1;
                        if (cur.full) begin
                            rd = rb[8:1];
                            chk("rx_data", rd, cur.data);
                            if (cur.pe) chk("rx_parity_error", rb[9] ^ (^rd ^ cur.pt), 0);
                            chk("rx_stop", rb[cur.pe ? 10 : 9], 1);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; data_valid = 1'b0; p_data = '0; par_en = 1'b0; par_type = 1'b0;
        repeat (3) @(negedge TX_CLK_TB);
        chk("rst_tx", tx_out, 1);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        mon_en = 1;
        @(negedge TX_CLK_TB);
        req(8'hBB, 1, 1, 1, 0); repeat (14) @(negedge TX_CLK_TB);
        req(8'hBB, 1, 0, 0, 0); repeat (14) @(negedge TX_CLK_TB);
        req(8'hBB, 0, 0, 0, 0); repeat (14) @(negedge TX_CLK_TB);
        req(8'h00, 1, 0, 0, 0); repeat (14) @(negedge TX_CLK_TB);
        req(8'hFF, 1, 1, 1, 0); repeat (14) @(negedge TX_CLK_TB);
        // new word and strobe during DATA cycle 3 must be ignored
        req(8'hBB, 1, 1, 1, 0);
        repeat (4) @(negedge TX_CLK_TB);
        p_data = 8'h55; data_valid = 1'b1;
        @(negedge TX_CLK_TB);
        data_valid = 1'b0;
        repeat (14) @(negedge TX_CLK_TB);
        // reset during DATA cycle 4 aborts the frame
        req(8'hBB, 1, 0, 0, 1);
        repeat (5) @(negedge TX_CLK_TB);
        rst_n = 1'b0;
        @(negedge TX_CLK_TB);
        rst_n = 1'b1;
        repeat (2) @(negedge TX_CLK_TB);
        req(8'hA5, 1, 1, 1, 0); repeat (14) @(negedge TX_CLK_TB);
        // request held across two frames
        @(negedge TX_CLK_TB);
        p_data = 8'hBB; par_en = 1'b1; par_type = 1'b1; data_valid = 1'b1;
        exp_q.push_back(mk(8'hBB, 1, 1, 1, 0, -1));
        exp_q.push_back(mk(8'h3C, 1, 0, 0, 0, 1));
        @(negedge TX_CLK_TB);
        p_data = 8'h3C; par_type = 1'b0;
        repeat (12) @(negedge TX_CLK_TB);
        data_valid = 1'b0;
        repeat (16) @(negedge TX_CLK_TB);
        chk("queue_empty", exp_q.size(), 0);
        chk("monitor_idle", pos, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 8, payload bits per frame.
REQ-002 SHALL have port: clk  input  1  bit-rate clock (one serial bit per cycle, 115.2 kHz nominal).
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port: p_data  input  DATA_WIDTH  parallel word to transmit.
REQ-005 SHALL have port: data_valid  input  1  request strobe; p_data, par_en and par_type valid while high.
REQ-006 SHALL have port: par_en  input  1  1 = parity bit inserted after data.
REQ-007 SHALL have port: par_type  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port: tx_out  output  1  serial line; idle-high, feeds the receiver's RX_IN.
REQ-009 SHALL have port: busy  output  1  high while a frame is on the line.

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-011 SHALL accept a request only when state = IDLE and data_valid = 1 at a rising clk edge; data_valid is ignored in every other state.
REQ-012 SHALL, on acceptance, latch p_data, par_en and par_type; input changes after acceptance SHALL NOT affect the frame in flight.
REQ-013 SHALL register tx_out and busy; the start bit appears one cycle after the accepting edge.
REQ-014 SHALL drive tx_out = 1, busy = 0 in IDLE.
REQ-015 SHALL drive tx_out = 0 in START for exactly 1 cycle, then go to DATA.
REQ-016 SHALL drive latched data bit i in DATA cycle i, i = 0..DATA_WIDTH-1 (LSB first), using a counter that wraps to 0 on leaving DATA.
REQ-017 SHALL go from the last DATA cycle to PARITY if latched par_en = 1, otherwise to STOP.
REQ-018 SHALL drive in PARITY (1 cycle): XOR-reduction of latched data if par_type = 0; its inverse if par_type = 1.
REQ-019 SHALL drive tx_out = 1 in STOP for exactly 1 cycle, then return to IDLE.
REQ-020 SHALL hold busy = 1 in START, DATA, PARITY and STOP; a frame is 11 cycles with parity, 10 without.
REQ-021 SHALL spend at least one IDLE cycle (busy = 0) between frames; a request held high across the STOP cycle is accepted on the first IDLE edge, so the next start bit follows STOP after exactly 1 idle cycle.
REQ-022 SHALL drive tx_out only to 0 or 1 after the first reset; no X or Z.

Reset
REQ-023 SHALL, at any rising clk edge with rst_n = 0, go to IDLE, set tx_out = 1, busy = 0, bit counter = 0 and clear latched data; this includes mid-frame, and the aborted frame is not resumed.
REQ-024 SHALL ignore data_valid on any edge where rst_n = 0.
REQ-025 SHALL have outputs that are not changed by rst_n between clock edges.

Verification
REQ-026 SHALL test 0xBB, par_en = 1, par_type = 1 -> tx_out 0,1,1,0,1,1,1,0,1,1,1 over 11 cycles (parity = 1); busy high for exactly those 11 cycles.
REQ-027 SHALL test 0xBB, par_en = 1, par_type = 0 -> parity bit = 0; 0xBB, par_en = 0 -> 10-cycle frame 0,1,1,0,1,1,1,0,1,1 with no parity slot.
REQ-028 SHALL test 0x00 even parity and 0xFF odd parity -> parity bits 0 and 1 respectively; data bits all 0 and all 1 respectively.
REQ-029 SHALL test p_data changed to 0x55 and data_valid pulsed in DATA cycle 3 -> frame still carries 0xBB; no second frame starts.
REQ-030 SHALL test rst_n = 0 for 1 cycle during DATA cycle 4 -> next cycle tx_out = 1, busy = 0; a new request then yields a complete, correct frame.
REQ-031 SHALL test data_valid held high over two frames -> second start bit exactly 1 idle cycle after first STOP; the loopback receiver configured identically reports matching data_valid and P_DATA with parity_error = 0 and framing_error = 0.
